// File: rtl/watchdog_ctrl.sv
// Memory-mapped watchdog timer that flushes the pipeline and redirects the PC to TRAP_VECTOR on expiry.
// Optional early-warning interrupt is built when WDT_PREWARN_EN is defined.
module watchdog_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        Flush,
  output logic        trap_pc_sel,
  output logic [31:0] trap_pc,
  output logic        wdt_irq
);

  typedef enum logic [1:0] {DISABLED, RUNNING, FLUSHING, TRAPPED} state_t;

  localparam logic [31:0] KICK_KEY   = 32'h0000_5A5A;
  localparam logic [3:0]  FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t      state, state_next;
  logic        ctrl_en;
  logic [31:0] load, load_next;
  logic [31:0] count, count_next;
  logic [3:0]  fcnt, fcnt_next;
  logic        status_expired;
  logic        status_warn;
  logic [31:0] warn;
  logic        set_expired;

  logic [31:0] off;
  logic        hit;
  logic        wr_ctrl, wr_kick, wr_load, wr_status;
  logic [31:0] rd_mux;

  // The window is word-aligned; anything else inside the range decodes as unmapped.
  assign off       = bus_addr - BASE_ADDR;
  assign hit       = (bus_addr >= BASE_ADDR) && (off <= 32'h14) && (off[1:0] == 2'b00);
  assign wr_ctrl   = bus_we && hit && (off[4:2] == 3'd0);
  assign wr_kick   = bus_we && hit && (off[4:2] == 3'd1);
  assign wr_load   = bus_we && hit && (off[4:2] == 3'd2);
  assign wr_status = bus_we && hit && (off[4:2] == 3'd4);

  assign load_next = wr_load ? ((bus_wdata == 32'd0) ? 32'd1 : bus_wdata) : load;
  assign trap_pc   = TRAP_VECTOR;

  always_comb begin
    rd_mux = 32'd0;
    case (off[4:2])
      3'd0:    rd_mux = {31'd0, ctrl_en};
      3'd2:    rd_mux = load;
      3'd3:    rd_mux = count;
      3'd4:    rd_mux = {30'd0, status_warn, status_expired};
      3'd5:    rd_mux = warn;
      default: rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    fcnt_next   = fcnt;
    set_expired = 1'b0;
    Flush       = 1'b0;
    trap_pc_sel = 1'b0;
    case (state)
      DISABLED: begin
        count_next = load_next;
        if (wr_ctrl && bus_wdata[0]) begin
          state_next = RUNNING;
          count_next = load;
        end
      end
      RUNNING: begin
        // A valid kick beats expiry when both land in the same cycle.
        if (wr_ctrl && !bus_wdata[0]) begin
          state_next = DISABLED;
          count_next = load;
        end else if (wr_kick && bus_wdata == KICK_KEY) begin
          count_next = load;
        end else if (wr_kick || count == 32'd0) begin
          state_next  = FLUSHING;
          count_next  = 32'd0;
          fcnt_next   = 4'd0;
          set_expired = 1'b1;
        end else begin
          count_next = count - 32'd1;
        end
      end
      FLUSHING: begin
        Flush       = 1'b1;
        trap_pc_sel = (fcnt == 4'd0);
        count_next  = 32'd0;
        if (fcnt == FLUSH_LAST) state_next = TRAPPED;
        else                    fcnt_next  = fcnt + 4'd1;
      end
      TRAPPED: begin
        count_next = 32'd0;
        if (wr_status && bus_wdata[0]) begin
          state_next = ctrl_en ? RUNNING : DISABLED;
          count_next = load;
        end
      end
      default: state_next = DISABLED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= DISABLED;
      ctrl_en        <= 1'b0;
      load           <= 32'h0000_FFFF;
      count          <= 32'h0000_FFFF;
      fcnt           <= 4'd0;
      status_expired <= 1'b0;
      bus_rdata      <= 32'd0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      fcnt      <= fcnt_next;
      load      <= load_next;
      bus_rdata <= (bus_re && hit) ? rd_mux : 32'd0;
      if (wr_ctrl) ctrl_en <= bus_wdata[0];
      if (set_expired)                    status_expired <= 1'b1;
      else if (wr_status && bus_wdata[0]) status_expired <= 1'b0;
    end
  end

`ifdef WDT_PREWARN_EN
  logic wr_warn;
  logic warn_hit;

  assign wr_warn  = bus_we && hit && (off[4:2] == 3'd5);
  assign warn_hit = (state == RUNNING) && (count == warn) && (warn != 32'd0);
  assign wdt_irq  = status_warn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warn        <= 32'd0;
      status_warn <= 1'b0;
    end else begin
      if (wr_warn) warn <= bus_wdata;
      if (warn_hit)                       status_warn <= 1'b1;
      else if (wr_status && bus_wdata[1]) status_warn <= 1'b0;
    end
  end
`else
  assign warn        = 32'd0;
  assign status_warn = 1'b0;
  assign wdt_irq     = 1'b0;
`endif

endmodule

// File: tb/tb_watchdog_ctrl.sv
// Directed self-checking bench for watchdog_ctrl; expectations are hand-derived cycle by cycle.
// Covers both builds of the WDT_PREWARN_EN option.
module tb_watchdog_ctrl;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_KICK = BASE + 32'h4;
  localparam logic [31:0] A_LOAD = BASE + 32'h8;
  localparam logic [31:0] A_COUNT = BASE + 32'hC;
  localparam logic [31:0] A_STATUS = BASE + 32'h10;
  localparam logic [31:0] A_WARN = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_addr = 32'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        Flush;
  logic        trap_pc_sel;
  logic [31:0] trap_pc;
  logic        wdt_irq;

  int vectors = 0;
  int miscompares = 0;

  watchdog_ctrl dut (
    .clk(clk), .rst(rst), .bus_we(bus_we), .bus_re(bus_re),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .Flush(Flush), .trap_pc_sel(trap_pc_sel), .trap_pc(trap_pc), .wdt_irq(wdt_irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_we = 1'b1; bus_addr = addr; bus_wdata = data;
    step();
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus_re = 1'b1; bus_addr = addr;
    step();
    bus_re = 1'b0;
    data = bus_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0;
    #2;
    vectors++;
    if ({Flush, trap_pc_sel, wdt_irq} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_outs: got %b expected 000", {Flush, trap_pc_sel, wdt_irq});
    end
    vectors++;
    if (bus_rdata !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_rdata: got %h expected 0", bus_rdata);
    end
    vectors++;
    if (trap_pc !== 32'h0000_0100) begin
      miscompares++;
      $display("[TB] FAIL trap_pc: got %h expected 00000100", trap_pc);
    end
    step();
    rst = 1'b1;
    step();
    bus_read(A_LOAD, d);
    vectors++;
    if (d !== 32'h0000_FFFF) begin
      miscompares++;
      $display("[TB] FAIL reset_load: got %h expected 0000ffff", d);
    end
    bus_read(A_COUNT, d);
    vectors++;
    if (d !== 32'h0000_FFFF) begin
      miscompares++;
      $display("[TB] FAIL reset_count: got %h expected 0000ffff", d);
    end
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %h expected 0", d);
    end
    bus_read(A_STATUS, d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_status: got %h expected 0", d);
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic [31:0] addrs [4] = '{A_KICK, BASE + 32'h18, BASE - 32'h4, BASE + 32'h2};
    bus_write(A_LOAD, 32'd0);
    bus_read(A_LOAD, d);
    vectors++;
    if (d !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL load_zero: got %h expected 1", d);
    end
    bus_read(A_COUNT, d);
    vectors++;
    if (d !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL count_tracks: got %h expected 1", d);
    end
    bus_we = 1'b1; bus_re = 1'b1; bus_addr = A_LOAD; bus_wdata = 32'd9;
    step();
    bus_we = 1'b0; bus_re = 1'b0;
    vectors++;
    if (bus_rdata !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL rw_prewrite: got %h expected 1", bus_rdata);
    end
    bus_read(A_LOAD, d);
    vectors++;
    if (d !== 32'd9) begin
      miscompares++;
      $display("[TB] FAIL load_after_rw: got %h expected 9", d);
    end
    step();
    vectors++;
    if (bus_rdata !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL rdata_idle: got %h expected 0", bus_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(addrs[i], d);
      vectors++;
      if (d !== 32'd0) begin
        miscompares++;
        $display("[TB] FAIL unmapped_%0d: got %h expected 0", i, d);
      end
    end
  endtask

  task automatic test_expiry();
    logic [31:0] d;
    logic ef, es;
    bus_write(A_LOAD, 32'd5);
    bus_write(A_CTRL, 32'd1);
    for (int k = 1; k <= 9; k++) begin
      step();
      ef = (k == 6) || (k == 7);
      es = (k == 6);
      vectors++;
      if (Flush !== ef || trap_pc_sel !== es) begin
        miscompares++;
        $display("[TB] FAIL expiry_cyc%0d: got flush=%b sel=%b expected flush=%b sel=%b",
                 k, Flush, trap_pc_sel, ef, es);
      end
    end
    bus_read(A_STATUS, d);
    vectors++;
    if (d !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL expiry_status: got %h expected 1", d);
    end
    bus_read(A_COUNT, d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL trapped_count: got %h expected 0", d);
    end
  endtask

  task automatic test_recover();
    logic [31:0] d;
    bus_write(A_STATUS, 32'd1);
    bus_read(A_COUNT, d);
    vectors++;
    if (d !== 32'd5) begin
      miscompares++;
      $display("[TB] FAIL recover_count: got %h expected 5", d);
    end
    bus_read(A_STATUS, d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL recover_status: got %h expected 0", d);
    end
  endtask

  task automatic test_bad_kick();
    logic [31:0] d;
    bus_write(A_KICK, 32'h0000_1234);
    vectors++;
    if (Flush !== 1'b1 || trap_pc_sel !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL badkick_flush: got flush=%b sel=%b expected 1 1", Flush, trap_pc_sel);
    end
    bus_write(A_LOAD, 32'd7);
    vectors++;
    if (Flush !== 1'b1 || trap_pc_sel !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_hold: got flush=%b sel=%b expected 1 0", Flush, trap_pc_sel);
    end
    step();
    vectors++;
    if (Flush !== 1'b0 || trap_pc_sel !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL trapped_outs: got flush=%b sel=%b expected 0 0", Flush, trap_pc_sel);
    end
    bus_read(A_STATUS, d);
    vectors++;
    if (d !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL badkick_status: got %h expected 1", d);
    end
    bus_read(A_LOAD, d);
    vectors++;
    if (d !== 32'd7) begin
      miscompares++;
      $display("[TB] FAIL flush_load_wr: got %h expected 7", d);
    end
    bus_write(A_KICK, 32'h0000_5A5A);
    bus_read(A_COUNT, d);
    vectors++;
    if (d !== 32'd0 || Flush !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL trapped_kick: got count=%h flush=%b expected 0 0", d, Flush);
    end
    bus_write(A_CTRL, 32'd0);
    bus_write(A_STATUS, 32'd1);
    for (int i = 0; i < 2; i++) begin
      bus_read(A_COUNT, d);
      vectors++;
      if (d !== 32'd7) begin
        miscompares++;
        $display("[TB] FAIL to_disabled_%0d: got %h expected 7", i, d);
      end
    end
  endtask

  task automatic test_kick_at_zero();
    logic [31:0] d;
    bus_write(A_LOAD, 32'd5);
    bus_write(A_CTRL, 32'd1);
    for (int k = 0; k < 5; k++) step();
    bus_write(A_KICK, 32'h0000_5A5A);
    vectors++;
    if (Flush !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL kick_zero_flush: got %b expected 0", Flush);
    end
    bus_read(A_COUNT, d);
    vectors++;
    if (d !== 32'd5) begin
      miscompares++;
      $display("[TB] FAIL kick_zero_count: got %h expected 5", d);
    end
    bus_write(A_CTRL, 32'd0);
  endtask

  task automatic test_prewarn();
    logic [31:0] d;
    logic ei;
    bus_write(A_LOAD, 32'd10);
    bus_write(A_WARN, 32'd3);
    bus_read(A_WARN, d);
`ifdef WDT_PREWARN_EN
    vectors++;
    if (d !== 32'd3) begin
      miscompares++;
      $display("[TB] FAIL warn_reg: got %h expected 3", d);
    end
`else
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL warn_reg: got %h expected 0", d);
    end
`endif
    bus_write(A_CTRL, 32'd1);
    for (int k = 1; k <= 9; k++) begin
      step();
`ifdef WDT_PREWARN_EN
      ei = (k >= 8);
`else
      ei = 1'b0;
`endif
      vectors++;
      if (wdt_irq !== ei) begin
        miscompares++;
        $display("[TB] FAIL irq_cyc%0d: got %b expected %b", k, wdt_irq, ei);
      end
    end
    bus_write(A_CTRL, 32'd0);
`ifdef WDT_PREWARN_EN
    ei = 1'b1;
`else
    ei = 1'b0;
`endif
    vectors++;
    if (wdt_irq !== ei) begin
      miscompares++;
      $display("[TB] FAIL irq_hold: got %b expected %b", wdt_irq, ei);
    end
    bus_write(A_STATUS, 32'd2);
    vectors++;
    if (wdt_irq !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL irq_clear: got %b expected 0", wdt_irq);
    end
  endtask

  task automatic test_reset_mid_flush();
    logic [31:0] d;
    int waited;
    bus_write(A_LOAD, 32'd2);
    bus_write(A_CTRL, 32'd1);
    waited = 0;
    while (Flush !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    vectors++;
    if (Flush !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_wait: got flush=%b after %0d cycles expected 1", Flush, waited);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (Flush !== 1'b0 || trap_pc_sel !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_flush_drop: got flush=%b sel=%b expected 0 0", Flush, trap_pc_sel);
    end
    #3;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (Flush !== 1'b0 || trap_pc_sel !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL post_rst_%0d: got flush=%b sel=%b expected 0 0", k, Flush, trap_pc_sel);
      end
    end
    for (int i = 0; i < 2; i++) begin
      bus_read(A_COUNT, d);
      vectors++;
      if (d !== 32'h0000_FFFF) begin
        miscompares++;
        $display("[TB] FAIL post_rst_count_%0d: got %h expected 0000ffff", i, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_expiry();
    test_recover();
    test_bad_kick();
    test_kick_at_zero();
    test_prewarn();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
